// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
//   Two-read, one-write register file feeding the ALU operand inputs.
//   Reads are registered (one-cycle operand fetch); writes land at the
//   rising clock edge. Every register is writable (no hardwired zero).
//
// Ports:
//   CLK          in   system clock, rising edge
//   RESETN       in   asynchronous active-low reset (clears storage and outputs)
//   IN           in   write data
//   INADDRESS    in   write register index
//   WRITE        in   write enable
//   OUT1ADDRESS  in   read port 1 index
//   OUT2ADDRESS  in   read port 2 index
//   OUT1         out  registered read data, port 1 (ALU DATA1)
//   OUT2         out  registered read data, port 2 (ALU DATA2)
//
// Build option:
//   REG_FILE_BYPASS_EN  defined   -> write-first: a read of the register
//                                    being written returns the new data
//                       undefined -> read-first: the read returns old data
module reg_file_2r1w #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] out1_q, out1_d;
    logic [DATA_W-1:0] out2_q, out2_d;

    always_comb begin
        regs_d = regs_q;
        if (WRITE) begin
            regs_d[INADDRESS] = IN;
        end

`ifdef REG_FILE_BYPASS_EN
        // Reading the post-write image forwards same-cycle write data.
        out1_d = regs_d[OUT1ADDRESS];
        out2_d = regs_d[OUT2ADDRESS];
`else
        out1_d = regs_q[OUT1ADDRESS];
        out2_d = regs_q[OUT2ADDRESS];
`endif
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            regs_q <= regs_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
        end
    end

    assign OUT1 = out1_q;
    assign OUT2 = out2_q;

endmodule
